// File: rtl/chunked_seq_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder_pkg
//   Shared definitions for the chunked sequential adder:
//   - state_t   : FSM state encoding (IDLE, RUN, DONE), 2 bits
//   - cnt_width : width of the slice counter for a given slice count
// ---------------------------------------------------------------------------
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one so a single-slice
  // build still has a legal counter register.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : chunked_seq_adder_pkg

// File: rtl/chunked_seq_adder_chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
//   Purely combinational CHUNK-bit adder: {o_cout, o_sum} = i_a + i_b + i_cin.
//   Its carry chain is the only one the chunked sequential adder evaluates
//   within one clock, so it bounds the critical path.
// Ports
//   i_a    in  CHUNK  operand slice A
//   i_b    in  CHUNK  operand slice B (already inverted for subtract)
//   i_cin  in  1      carry into the slice
//   o_sum  out CHUNK  slice sum
//   o_cout out 1      carry out of the slice
// ---------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_full;

  // One extra bit of headroom captures the slice carry-out.
  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];

endmodule : chunk_adder

// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle add/subtract unit. WIDTH-bit operands are resolved CHUNK bits
//   per clock, least-significant slice first, using one chunk_adder and a
//   registered carry between slices. Latency is WIDTH/CHUNK clocks from the
//   accepting edge to the done pulse.
// Ports
//   i_clk    in  1      rising-edge clock
//   i_rst    in  1      asynchronous active-high reset (aborts any operation)
//   i_start  in  1      request, sampled only while not busy
//   i_sub    in  1      0: a+b+cin, 1: a+~b+1 (cin ignored)
//   i_a      in  WIDTH  operand A, latched at accepted start
//   i_b      in  WIDTH  operand B, latched at accepted start
//   i_cin    in  1      carry-in for add mode, latched at accepted start
//   o_busy   out 1      high while slices are being computed
//   o_done   out 1      one-cycle pulse: o_sum/o_cout/o_ovf valid
//   o_sum    out WIDTH  result (partially updated while busy)
//   o_cout   out 1      carry out of MSB (subtract: 1 = no borrow)
//   o_ovf    out 1      two's complement overflow
// ---------------------------------------------------------------------------
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  // Guarded so an illegal CHUNK cannot itself cause a divide-by-zero.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = WIDTH / CHUNK_SAFE;
  localparam int CW         = cnt_width(N);
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
      $error("chunked_seq_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  // Registered state
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // effective B: already inverted for subtract
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  // Slice datapath
  logic [31:0]      w_shamt;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_ovf_next;

  // Bring the active slice of each operand down to bit 0.
  assign w_shamt   = 32'(r_cnt) * CHUNK;
  assign w_a_shift = r_a >> w_shamt;
  assign w_b_shift = r_b >> w_shamt;
  assign w_a_slice = w_a_shift[CHUNK-1:0];
  assign w_b_slice = w_b_shift[CHUNK-1:0];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Merge the freshly computed slice into the running sum.
  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CW'(i)) begin
        w_sum_next[i*CHUNK +: CHUNK] = w_slice_sum;
      end else begin
        w_sum_next[i*CHUNK +: CHUNK] = r_sum[i*CHUNK +: CHUNK];
      end
    end
  end

  // Overflow: operands agree in sign but the result does not. Only meaningful
  // on the last slice, which is the one that produces the MSB.
  assign w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE for a new request, which allows
        // back-to-back operations without an idle gap.
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_sum   <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // One slice per clock; i_start and operand inputs are ignored here.
        ST_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          if (r_cnt == LAST_SLICE) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= w_ovf_next;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule : chunked_seq_adder

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder
//   Self-checking bench for chunked_seq_adder. A 16/4 instance carries the
//   bulk of the directed and random operations; a 16/16 instance covers the
//   single-slice build. Expected results come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 16/4 instance
  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic        cin   = 1'b0;
  logic [15:0] a     = 16'h0000;
  logic [15:0] b     = 16'h0000;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  // 16/16 instance
  logic        start1 = 1'b0;
  logic        sub1   = 1'b0;
  logic        cin1   = 1'b0;
  logic [15:0] a1     = 16'h0000;
  logic [15:0] b1     = 16'h0000;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int checks = 0;
  int errors = 0;
  logic [17:0] last_exp = 18'h0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
  );

  chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_sub(sub1),
    .i_a(a1), .i_b(b1), .i_cin(cin1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int ua, ub, sa, sb, u, s;
    logic [17:0] r;
    ua = int'({16'd0, ma});
    ub = int'({16'd0, mb});
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      u = ua + 65536 - ub;
      s = sa - sb;
    end else begin
      u = ua + ub + int'({31'd0, mcin});
      s = sa + sb + int'({31'd0, mcin});
    end
    r[15:0] = u[15:0];
    r[16]   = u[16];
    r[17]   = (s > 32767) || (s < -32768);
    return r;
  endfunction

  // Start an op on the 16/4 instance from just after a clock edge and follow
  // it to its done pulse. Inputs are scrambled while busy; with poke set,
  // start is also raised during RUN. Returns just after the done edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, input bit poke);
    logic [17:0] exp;
    exp = model(ta, tb_v, tcin, tsub);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_sum_clear", 32'(sum), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      start = (poke && (k == 2)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (k < 4) begin
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
      end else begin
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_done", 32'(done), 32'd1);
        check("fin_sum", 32'(sum), 32'(exp[15:0]));
        check("fin_cout", 32'(cout), 32'(exp[16]));
        check("fin_ovf", 32'(ovf), 32'(exp[17]));
      end
    end
    start = 1'b0;
    last_exp = exp;
  endtask

  // One idle clock after done: pulse drops, results hold.
  task automatic idle_hold();
    @(posedge clk); #1;
    check("hold_done", 32'(done), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_sum", 32'(sum), 32'(last_exp[15:0]));
    check("hold_cout", 32'(cout), 32'(last_exp[16]));
    check("hold_ovf", 32'(ovf), 32'(last_exp[17]));
  endtask

  // Single-slice instance: done one edge after the accepting edge.
  task automatic run_op1(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub);
    logic [17:0] exp;
    exp = model(ta, tb_v, tcin, tsub);
    a1 = ta; b1 = tb_v; cin1 = tcin; sub1 = tsub; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 16'($urandom); b1 = 16'($urandom);
    check("c16_accept_busy", 32'(busy1), 32'd1);
    check("c16_accept_done", 32'(done1), 32'd0);
    @(posedge clk); #1;
    check("c16_busy", 32'(busy1), 32'd0);
    check("c16_done", 32'(done1), 32'd1);
    check("c16_sum", 32'(sum1), 32'(exp[15:0]));
    check("c16_cout", 32'(cout1), 32'(exp[16]));
    check("c16_ovf", 32'(ovf1), 32'(exp[17]));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0); idle_hold();
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0); idle_hold();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0); idle_hold();
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0); idle_hold();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0); idle_hold();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1); idle_hold();

    // Reset at the second RUN edge aborts immediately, no done follows.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0); idle_hold();

    // Back-to-back: second start lands in the DONE cycle.
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0); idle_hold();

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 0) begin
        idle_hold();
      end
    end
    idle_hold();

    // Single-slice build
    run_op1(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op1(16'h8000, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_op1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_chunked_seq_adder
